// File: rtl/vga_pkg.sv
// Shared VGA geometry and obstacle defaults for the rendering chain.
package vga_pkg;

    localparam int HOR_PIXELS = 800;
    localparam int VER_PIXELS = 600;

    localparam int          OBST_W_DEF   = 40;
    localparam int          OBST_H_DEF   = 60;
    localparam int          OBST_Y_DEF   = 500;
    localparam logic [11:0] OBST_RGB_DEF = 12'hF00;
    localparam logic [11:0] BG_RGB_DEF   = 12'h8BF;

    typedef struct packed {
        logic [10:0] hcount;
        logic [10:0] vcount;
        logic        hsync;
        logic        vsync;
        logic        hblnk;
        logic        vblnk;
    } vga_timing_t;

endpackage

// File: rtl/vga_delay.sv
// N-stage register for the VGA timing bundle (coordinates, syncs, blanking).
module vga_delay
    import vga_pkg::*;
#(
    parameter int N = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  vga_timing_t timing_in,
    output vga_timing_t timing_out
);

    vga_timing_t pipe [N];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N; i++) pipe[i] <= '0;
        end else begin
            pipe[0] <= timing_in;
            for (int i = 1; i < N; i++) pipe[i] <= pipe[i-1];
        end
    end

    assign timing_out = pipe[N-1];

endmodule

// File: rtl/draw_obstacle.sv
// Overlays a solid obstacle rectangle on the VGA stream; X position is latched
// once per frame and a sticky flag reports overlap with non-background pixels.
module draw_obstacle
    import vga_pkg::*;
#(
    parameter int          OBST_W   = OBST_W_DEF,
    parameter int          OBST_H   = OBST_H_DEF,
    parameter int          OBST_Y   = OBST_Y_DEF,
    parameter logic [11:0] OBST_RGB = OBST_RGB_DEF,
    parameter logic [11:0] BG_RGB   = BG_RGB_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [11:0] obstacle_xpos,
    input  logic [10:0] hcount_in,
    input  logic [10:0] vcount_in,
    input  logic        hsync_in,
    input  logic        vsync_in,
    input  logic        hblnk_in,
    input  logic        vblnk_in,
    input  logic [11:0] rgb_in,
    output logic [10:0] hcount_out,
    output logic [10:0] vcount_out,
    output logic        hsync_out,
    output logic        vsync_out,
    output logic        hblnk_out,
    output logic        vblnk_out,
    output logic [11:0] rgb_out,
    output logic        collision
);

    logic        vblnk_d;
    logic [11:0] xpos_frame;
    logic        frame_start;
    logic [12:0] x_lo;
    logic [12:0] x_hi;
    logic        in_rect;

    vga_timing_t timing_p0;
    vga_timing_t timing_p2;

    logic [11:0] rgb_p1;
    logic        in_rect_p1;
    logic        hblnk_p1;
    logic        vblnk_p1;
    logic        blank_p1;
    logic        hit_p1;

    assign frame_start = vblnk_in & ~vblnk_d;

    // End of the rectangle is formed at 13 bits so positions near 4095 cannot wrap.
    assign x_lo    = {1'b0, xpos_frame};
    assign x_hi    = x_lo + 13'(OBST_W);
    assign in_rect = (xpos_frame != 12'd0)
                  && ({2'b00, hcount_in} >= x_lo)
                  && ({2'b00, hcount_in} <  x_hi)
                  && (vcount_in >= 11'(OBST_Y))
                  && (vcount_in <  11'(OBST_Y + OBST_H));

    always_ff @(posedge clk) begin
        if (rst) begin
            vblnk_d    <= 1'b0;
            xpos_frame <= 12'd0;
        end else begin
            vblnk_d <= vblnk_in;
            if (frame_start) xpos_frame <= obstacle_xpos;
        end
    end

    assign timing_p0 = '{hcount: hcount_in, vcount: vcount_in, hsync: hsync_in,
                         vsync: vsync_in, hblnk: hblnk_in, vblnk: vblnk_in};

    vga_delay #(.N(2)) u_timing_delay (
        .clk        (clk),
        .rst        (rst),
        .timing_in  (timing_p0),
        .timing_out (timing_p2)
    );

    // Stage 1: pixel colour, blanking and rectangle hit
    always_ff @(posedge clk) begin
        if (rst) begin
            rgb_p1     <= 12'd0;
            in_rect_p1 <= 1'b0;
            hblnk_p1   <= 1'b0;
            vblnk_p1   <= 1'b0;
        end else begin
            rgb_p1     <= rgb_in;
            in_rect_p1 <= in_rect;
            hblnk_p1   <= hblnk_in;
            vblnk_p1   <= vblnk_in;
        end
    end

    assign blank_p1 = hblnk_p1 | vblnk_p1;
    assign hit_p1   = in_rect_p1 & ~blank_p1 & (rgb_p1 != BG_RGB);

    // Stage 2: composited colour and collision flag
    always_ff @(posedge clk) begin
        if (rst) begin
            rgb_out   <= 12'd0;
            collision <= 1'b0;
        end else begin
            if (blank_p1)        rgb_out <= 12'h000;
            else if (in_rect_p1) rgb_out <= OBST_RGB;
            else                 rgb_out <= rgb_p1;

            if (hit_p1)           collision <= 1'b1;
            else if (frame_start) collision <= 1'b0;
        end
    end

    assign hcount_out = timing_p2.hcount;
    assign vcount_out = timing_p2.vcount;
    assign hsync_out  = timing_p2.hsync;
    assign vsync_out  = timing_p2.vsync;
    assign hblnk_out  = timing_p2.hblnk;
    assign vblnk_out  = timing_p2.vblnk;

endmodule

// File: tb/tb_draw_obstacle.sv
// Scoreboard bench for draw_obstacle: compressed raster frames with random pixels.
module tb_draw_obstacle;

    localparam logic [11:0] BG = 12'h8BF;
    localparam logic [11:0] OB = 12'hF00;

    logic        clk = 1'b0;
    logic        rst;
    logic [11:0] obstacle_xpos;
    logic [10:0] hcount_in, vcount_in;
    logic        hsync_in, vsync_in, hblnk_in, vblnk_in;
    logic [11:0] rgb_in;
    logic [10:0] hcount_out, vcount_out;
    logic        hsync_out, vsync_out, hblnk_out, vblnk_out;
    logic [11:0] rgb_out;
    logic        collision;

    always #5 clk = ~clk;

    draw_obstacle dut (
        .clk           (clk),
        .rst           (rst),
        .obstacle_xpos (obstacle_xpos),
        .hcount_in     (hcount_in),
        .vcount_in     (vcount_in),
        .hsync_in      (hsync_in),
        .vsync_in      (vsync_in),
        .hblnk_in      (hblnk_in),
        .vblnk_in      (vblnk_in),
        .rgb_in        (rgb_in),
        .hcount_out    (hcount_out),
        .vcount_out    (vcount_out),
        .hsync_out     (hsync_out),
        .vsync_out     (vsync_out),
        .hblnk_out     (hblnk_out),
        .vblnk_out     (vblnk_out),
        .rgb_out       (rgb_out),
        .collision     (collision)
    );

    typedef struct {
        int          due;
        logic [10:0] h;
        logic [10:0] v;
        logic        hs;
        logic        vs;
        logic        hb;
        logic        vb;
        logic [11:0] rgb;
        logic        col;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   n_checks = 0;
    int   n_pass = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp_v);
        n_checks++;
        if (act == exp_v) n_pass++;
        else $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp_v);
    endtask

    // Reference model state: latched X, previous vblank as seen by the frame
    // detector, the cycle from which hits still count, and the latest hit.
    logic [11:0] m_xpos = 12'd0;
    bit          m_prev_vb = 1'b0;
    int          thr = 0;
    int          last_hit = -100;
    exp_t        pend;
    bit          pend_ok = 1'b0;
    bit          pend_zero = 1'b0;

    task automatic issue(input bit r, input int h, input int v,
                         input logic [11:0] rgb_v, input logic [11:0] xin);
        bit hb, vb, blank, fs, ir;
        int c, xi;
        @(posedge clk);
        #1;
        c     = cyc;
        hb    = (h >= 800);
        vb    = (v >= 600);
        blank = hb || vb;
        rst           = r;
        hcount_in     = 11'(h);
        vcount_in     = 11'(v);
        hsync_in      = (h >= 800 && h < 804);
        vsync_in      = (v == 601);
        hblnk_in      = hb;
        vblnk_in      = vb;
        rgb_in        = rgb_v;
        obstacle_xpos = xin;

        xi = int'(m_xpos);
        ir = (xi != 0) && (h >= xi) && (h < xi + 40) && (v >= 500) && (v < 560);
        fs = vb && !m_prev_vb;
        if (r) begin
            thr       = c + 1;
            m_xpos    = 12'd0;
            m_prev_vb = 1'b0;
        end else begin
            if (fs) begin
                if (c - 1 > thr) thr = c - 1;
                m_xpos = xin;
            end
            m_prev_vb = vb;
        end

        if (pend_ok) begin
            if (pend_zero || r) begin
                pend.h = '0; pend.v = '0; pend.hs = 0; pend.vs = 0;
                pend.hb = 0; pend.vb = 0; pend.rgb = '0; pend.col = 0;
            end else begin
                pend.col = (last_hit >= thr);
            end
            q.push_back(pend);
        end

        pend.due  = c + 2;
        pend.h    = 11'(h);
        pend.v    = 11'(v);
        pend.hs   = (h >= 800 && h < 804);
        pend.vs   = (v == 601);
        pend.hb   = hb;
        pend.vb   = vb;
        pend.rgb  = blank ? 12'h000 : (ir ? OB : rgb_v);
        pend.col  = 1'b0;
        pend_zero = r;
        pend_ok   = 1'b1;
        if (!r && ir && !blank && rgb_v != BG) last_hit = c;
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            while (q.size() > 0 && q[0].due <= cyc) begin
                e = q.pop_front();
                chk("due_cycle", cyc, e.due);
                chk("rgb_out", int'(rgb_out), int'(e.rgb));
                chk("timing_out",
                    int'({hcount_out, vcount_out, hsync_out, vsync_out, hblnk_out, vblnk_out}),
                    int'({e.h, e.v, e.hs, e.vs, e.hb, e.vb}));
                chk("collision", int'(collision), int'(e.col));
            end
        end
    end

    initial begin
        int          lines[14] = '{0, 499, 500, 501, 515, 520, 530, 545, 558, 559, 560, 561, 600, 601};
        int          xtab[8]   = '{300, 299, 300, 0, 780, 4090, 330, 300};
        bit          noise[8]  = '{0, 0, 0, 1, 1, 1, 1, 1};
        bit          inject[8] = '{0, 0, 1, 0, 0, 0, 0, 1};
        int          hl[$];
        logic [11:0] cur_x;
        logic [11:0] px;
        bit          r;

        rst = 1'b1; obstacle_xpos = '0; hcount_in = '0; vcount_in = '0;
        hsync_in = 0; vsync_in = 0; hblnk_in = 0; vblnk_in = 0; rgb_in = '0;

        for (int h = 0; h < 16; h++)     hl.push_back(h);
        for (int h = 280; h <= 350; h++) hl.push_back(h);
        for (int h = 760; h <= 807; h++) hl.push_back(h);

        cur_x = 12'd300;
        for (int k = 0; k < 3; k++) issue(1'b1, 300 + 4 * k, 530, 12'($urandom), cur_x);

        for (int f = 0; f < 8; f++) begin
            foreach (lines[li]) begin
                foreach (hl[j]) begin
                    int h, v;
                    h = hl[j];
                    v = lines[li];
                    if (v == 520 && j == 0) cur_x = 12'(xtab[f]);
                    r = (f == 6 && v == 600 && h >= 5 && h < 8);
                    if (h >= 800 || v >= 600)                         px = 12'($urandom);
                    else if (inject[f] && h == 310 && v == 530)       px = 12'h0F0;
                    else if (noise[f] && $urandom_range(0, 15) == 0)  px = 12'($urandom);
                    else                                              px = BG;
                    issue(r, h, v, px, cur_x);
                end
            end
        end

        for (int k = 0; k < 3; k++) issue(1'b0, 0, 0, BG, cur_x);
        repeat (4) @(posedge clk);
        #1;
        chk("scoreboard_drained", q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
